// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state and latched request.
// Struct widths are fixed here; mem_arbiter's width parameters are expected to match them.
package rv32i_types;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_MBE_W  = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_MBE_W-1:0]  mbe;
    logic                  read;
    logic                  write;
  } arb_req_t;

  // A simultaneous read+write is issued as a write; reads carry all-ones mbe and zero wdata.
  function automatic arb_req_t make_data_req(input logic [ARB_ADDR_W-1:0] addr,
                                             input logic [ARB_DATA_W-1:0] wdata,
                                             input logic [ARB_MBE_W-1:0]  mbe,
                                             input logic                  rd,
                                             input logic                  wr);
    arb_req_t r;
    r.addr  = addr;
    r.write = wr;
    r.read  = rd & ~wr;
    r.wdata = wr ? wdata : '0;
    r.mbe   = wr ? mbe : '1;
    return r;
  endfunction

  function automatic arb_req_t make_fetch_req(input logic [ARB_ADDR_W-1:0] addr);
    arb_req_t r;
    r.addr  = addr;
    r.wdata = '0;
    r.mbe   = '1;
    r.read  = 1'b1;
    r.write = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port seen by mem_arbiter.
// valid/ready: inst_read/data_read/data_write and mem_read/mem_write are held until the matching 1-cycle *_resp pulse.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    inst_read;
  logic [ADDR_WIDTH-1:0]   inst_addr;
  logic                    inst_resp;
  logic [DATA_WIDTH-1:0]   inst_rdata;

  logic                    data_read;
  logic                    data_write;
  logic [DATA_WIDTH/8-1:0] data_mbe;
  logic [ADDR_WIDTH-1:0]   data_addr;
  logic [DATA_WIDTH-1:0]   data_wdata;
  logic                    data_resp;
  logic [DATA_WIDTH-1:0]   data_rdata;

  logic                    mem_read;
  logic                    mem_write;
  logic [DATA_WIDTH/8-1:0] mem_mbe;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_resp;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // Arbiter side
  modport slave (
    input  inst_read, inst_addr,
    output inst_resp, inst_rdata,
    input  data_read, data_write, data_mbe, data_addr, data_wdata,
    output data_resp, data_rdata,
    output mem_read, mem_write, mem_mbe, mem_addr, mem_wdata,
    input  mem_resp, mem_rdata
  );

  // Requester and memory side
  modport master (
    output inst_read, inst_addr,
    input  inst_resp, inst_rdata,
    output data_read, data_write, data_mbe, data_addr, data_wdata,
    input  data_resp, data_rdata,
    input  mem_read, mem_write, mem_mbe, mem_addr, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_perf.sv
// Wrapping event counters for the arbiter: completed fetches, completed data accesses, IDLE conflicts.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_evt_i,
  input  logic                 data_evt_i,
  input  logic                 conf_evt_i,
  output logic [CNT_WIDTH-1:0] inst_cnt_o,
  output logic [CNT_WIDTH-1:0] data_cnt_o,
  output logic [CNT_WIDTH-1:0] conf_cnt_o
);
  logic [CNT_WIDTH-1:0] inst_cnt_q, data_cnt_q, conf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_cnt_q <= '0;
      data_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (inst_evt_i) inst_cnt_q <= inst_cnt_q + 1'b1;
      if (data_evt_i) data_cnt_q <= data_cnt_q + 1'b1;
      if (conf_evt_i) conf_cnt_q <= conf_cnt_q + 1'b1;
    end
  end

  assign inst_cnt_o = inst_cnt_q;
  assign data_cnt_o = data_cnt_q;
  assign conf_cnt_o = conf_cnt_q;
endmodule

// File: rtl/mem_arbiter.sv
// Merges fetch and data ports onto one shared memory port; data wins arbitration in IDLE.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH     = ARB_ADDR_W,
  parameter int DATA_WIDTH     = ARB_DATA_W,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  mem_arbiter_if.slave              bus,
  output arb_state_t                dbg_state_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] perf_inst_cnt,
  output logic [PERF_CNT_WIDTH-1:0] perf_data_cnt,
  output logic [PERF_CNT_WIDTH-1:0] perf_conf_cnt
`endif
);
  localparam int MBE_W = DATA_WIDTH / 8;

  arb_state_t state_q, state_d;
  arb_req_t   req_q, req_d;
  logic       data_req_any;

  assign data_req_any = bus.data_read | bus.data_write;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (data_req_any) begin
          state_d = DATA;
          req_d   = make_data_req(ARB_ADDR_W'(bus.data_addr), ARB_DATA_W'(bus.data_wdata),
                                  ARB_MBE_W'(bus.data_mbe), bus.data_read, bus.data_write);
        end else if (bus.inst_read) begin
          state_d = INST;
          req_d   = make_fetch_req(ARB_ADDR_W'(bus.inst_addr));
        end
      end
      // Completion clears the request regs so strobes drop the cycle after mem_resp.
      INST, DATA: begin
        if (bus.mem_resp) begin
          state_d = IDLE;
          req_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  assign bus.mem_read  = req_q.read;
  assign bus.mem_write = req_q.write;
  assign bus.mem_mbe   = MBE_W'(req_q.mbe);
  assign bus.mem_addr  = ADDR_WIDTH'(req_q.addr);
  assign bus.mem_wdata = DATA_WIDTH'(req_q.wdata);

  // Responses are a same-cycle pass-through of mem_resp to whichever port owns the access.
  assign bus.inst_resp  = (state_q == INST) & bus.mem_resp;
  assign bus.data_resp  = (state_q == DATA) & bus.mem_resp;
  assign bus.inst_rdata = bus.inst_resp ? bus.mem_rdata : '0;
  assign bus.data_rdata = bus.data_resp ? bus.mem_rdata : '0;

  assign dbg_state_o = state_q;

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf #(
    .CNT_WIDTH (PERF_CNT_WIDTH)
  ) u_perf (
    .clk        (clk),
    .rst        (rst),
    .inst_evt_i (bus.inst_resp),
    .data_evt_i (bus.data_resp),
    .conf_evt_i ((state_q == IDLE) & bus.inst_read & data_req_any),
    .inst_cnt_o (perf_inst_cnt),
    .data_cnt_o (perf_data_cnt),
    .conf_cnt_o (perf_conf_cnt)
  );
`endif

endmodule
